// File: rtl/apb_read_data_packer_pkg.sv
// Shared widths, lane indices and FSM encoding for the APB read-data packer.
package apb_read_data_packer_pkg;

  localparam int RAH_PACKET_WIDTH = 48;
  localparam int READ_DATA_WIDTH  = 16;
  localparam int LENGTH_WIDTH     = 8;
  localparam int SLV_ID_WIDTH     = 7;

  localparam logic RAH_HDR_MARK = 1'b1;

  // Lane index of each 16-bit slot inside the packet; words fill slot2 first.
  localparam logic [1:0] LANE_SLOT0 = 2'd0;
  localparam logic [1:0] LANE_SLOT1 = 2'd1;
  localparam logic [1:0] LANE_SLOT2 = 2'd2;

  typedef enum logic [1:0] {
    RDP_IDLE = 2'd0,
    RDP_FILL = 2'd1,
    RDP_SEND = 2'd2
  } rdp_state_t;

endpackage

// File: rtl/apb_read_data_packer.sv
// Packs 16-bit APB read words into 48-bit RAH packets: the first packet carries
// the response header plus two words, every later packet carries three words.
module apb_read_data_packer
  import apb_read_data_packer_pkg::*;
#(
  parameter int RAH_PACKET_WIDTH_P = RAH_PACKET_WIDTH,
  parameter int READ_DATA_WIDTH_P  = READ_DATA_WIDTH,
  parameter int LENGTH_WIDTH_P     = LENGTH_WIDTH,
  parameter int SLV_ID_WIDTH_P     = SLV_ID_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_start,
  input  logic [SLV_ID_WIDTH_P-1:0]     rd_slv_id,
  input  logic [LENGTH_WIDTH_P-1:0]     rd_length,
  input  logic                          rd_valid,
  input  logic [READ_DATA_WIDTH_P-1:0]  rd_data,
  output logic                          rd_ready,
  output logic                          pkt_valid,
  output logic [RAH_PACKET_WIDTH_P-1:0] pkt_data,
  output logic                          pkt_first,
  output logic                          pkt_last,
  input  logic                          pkt_ready,
  output logic                          busy,
  output logic                          start_err
);

  localparam int W = READ_DATA_WIDTH_P;

  rdp_state_t                    state, next_state;
  logic [RAH_PACKET_WIDTH_P-1:0] buffer;
  logic [LENGTH_WIDTH_P-1:0]     remaining;
  logic [1:0]                    slot;
  logic                          first;
  logic                          start_err_q;

  logic start_ok;
  logic word_take;
  logic fill_done;
  logic send_done;

  assign start_ok  = (state == RDP_IDLE) && rd_start && (rd_length != '0);
  assign word_take = (state == RDP_FILL) && rd_valid;
  assign fill_done = word_take &&
                     ((slot == LANE_SLOT0) || (remaining == LENGTH_WIDTH_P'(1)));
  assign send_done = (state == RDP_SEND) && pkt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RDP_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RDP_IDLE: if (start_ok) next_state = RDP_FILL;
      RDP_FILL: if (fill_done) next_state = RDP_SEND;
      RDP_SEND: if (send_done) next_state = (remaining == '0) ? RDP_IDLE : RDP_FILL;
      default:  next_state = RDP_IDLE;
    endcase
  end

  // pkt_data is only exposed in SEND so a half-filled buffer never leaks out.
  always_comb begin
    rd_ready  = 1'b0;
    pkt_valid = 1'b0;
    pkt_data  = '0;
    pkt_first = 1'b0;
    pkt_last  = 1'b0;
    busy      = (state != RDP_IDLE);
    case (state)
      RDP_FILL: rd_ready = 1'b1;
      RDP_SEND: begin
        pkt_valid = 1'b1;
        pkt_data  = buffer;
        pkt_first = first;
        pkt_last  = (remaining == '0);
      end
      default: ;
    endcase
  end

  assign start_err = start_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer      <= '0;
      remaining   <= '0;
      slot        <= LANE_SLOT2;
      first       <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      start_err_q <= rd_start && ((state != RDP_IDLE) || (rd_length == '0));

      if (start_ok) begin
        buffer    <= {RAH_HDR_MARK, rd_slv_id, rd_length, {(2*W){1'b0}}};
        remaining <= rd_length;
        slot      <= LANE_SLOT1;
        first     <= 1'b1;
      end

      if (word_take) begin
        case (slot)
          LANE_SLOT2: buffer[2*W +: W] <= rd_data;
          LANE_SLOT1: buffer[W   +: W] <= rd_data;
          LANE_SLOT0: buffer[0   +: W] <= rd_data;
          default:    ;
        endcase
        remaining <= remaining - LENGTH_WIDTH_P'(1);
        slot      <= slot - 2'd1;
      end

      // Continuation packets start empty so short tails come out zero-padded.
      if (send_done) begin
        buffer <= '0;
        if (remaining == '0) begin
          slot  <= LANE_SLOT2;
          first <= 1'b0;
        end else begin
          slot  <= LANE_SLOT2;
          first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_read_data_packer.sv
// Directed bench for apb_read_data_packer: a packet-list model built from the
// response rules, checked every cycle, plus literal pins on captured packets.
module tb_apb_read_data_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd_start = 1'b0;
  logic [6:0]  rd_slv_id = '0;
  logic [7:0]  rd_length = '0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic        rd_ready;
  logic        pkt_valid;
  logic [47:0] pkt_data;
  logic        pkt_first;
  logic        pkt_last;
  logic        pkt_ready = 1'b1;
  logic        busy;
  logic        start_err;

  apb_read_data_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_start  (rd_start),
    .rd_slv_id (rd_slv_id),
    .rd_length (rd_length),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data),
    .pkt_first (pkt_first),
    .pkt_last  (pkt_last),
    .pkt_ready (pkt_ready),
    .busy      (busy),
    .start_err (start_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] data;
    logic        first;
    logic        last;
    int          nwords;
  } pkt_t;

  pkt_t        exp_q[$];
  logic [15:0] src_q[$];
  logic [15:0] words[$];
  logic [47:0] pkt_log[$];
  int          checks = 0;
  int          errors = 0;
  int          got = 0;
  bit          pkt_due = 1'b0;
  int          stall_cnt = 0;
  int          stalled = 0;

  task automatic check_output(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Splits a response into packets: header + 2 words, then groups of 3, zero-padded.
  task automatic build_packets(input logic [6:0] id, input int len);
    pkt_t p;
    int   idx;
    p.data   = {1'b1, id, 8'(len), words[0], (len > 1) ? words[1] : 16'h0000};
    p.first  = 1'b1;
    p.last   = (len <= 2);
    p.nwords = (len < 2) ? len : 2;
    exp_q.push_back(p);
    idx = 2;
    while (idx < len) begin
      p.data   = '0;
      p.nwords = 0;
      for (int k = 0; k < 3; k++) begin
        if (idx + k < len) begin
          p.data[47 - 16*k -: 16] = words[idx + k];
          p.nwords++;
        end
      end
      p.first = 1'b0;
      p.last  = (idx + 3 >= len);
      exp_q.push_back(p);
      idx += 3;
    end
    foreach (words[i]) src_q.push_back(words[i]);
  endtask

  task automatic make_words(input logic [15:0] base, input int len);
    words = {};
    for (int i = 0; i < len; i++) words.push_back(base + 16'(i));
  endtask

  // Called aligned at posedge+1; leaves the bench aligned at posedge+1.
  task automatic apply_stimulus(input string name, input logic [6:0] id, input int len, input bit exp_err);
    rd_start  = 1'b1;
    rd_slv_id = id;
    rd_length = 8'(len);
    if (!exp_err) build_packets(id, len);
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(negedge clk);
    check_output({name, "_start_err"}, 48'(start_err), 48'(exp_err));
    @(negedge clk);
    check_output({name, "_start_err_pulse"}, 48'(start_err), 48'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    int c;
    for (c = 0; c < 300; c++) begin
      if (exp_q.size() == 0 && src_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (c == 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d packets pending expected 0", name, exp_q.size());
    end
    @(negedge clk);
    check_output({name, "_busy_after"}, 48'(busy), 48'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, "_rd_ready"},  48'(rd_ready),  48'd0);
    check_output({name, "_pkt_valid"}, 48'(pkt_valid), 48'd0);
    check_output({name, "_pkt_data"},  pkt_data,       48'd0);
    check_output({name, "_pkt_first"}, 48'(pkt_first), 48'd0);
    check_output({name, "_pkt_last"},  48'(pkt_last),  48'd0);
    check_output({name, "_busy"},      48'(busy),      48'd0);
    check_output({name, "_start_err"}, 48'(start_err), 48'd0);
  endtask

  // Word source: holds a word on rd_data until it is seen accepted.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = rst_n && rd_valid && rd_ready;
      @(posedge clk); #1;
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      rd_valid = (src_q.size() > 0);
      rd_data  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
    end
  end

  // Packet sink: back-pressures for stall_cnt valid cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (pkt_valid && stall_cnt > 0) stall_cnt--;
      @(posedge clk); #1;
      pkt_ready = (stall_cnt == 0);
    end
  end

  // Per-cycle comparison against the packet model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_output("pkt_valid_timing", 48'(pkt_valid), 48'(pkt_due));
        if (pkt_valid && exp_q.size() > 0) begin
          check_output("pkt_data",  pkt_data,        exp_q[0].data);
          check_output("pkt_first", 48'(pkt_first),  48'(exp_q[0].first));
          check_output("pkt_last",  48'(pkt_last),   48'(exp_q[0].last));
          check_output("rd_ready_in_send", 48'(rd_ready), 48'd0);
          if (!pkt_ready) stalled++;
          if (pkt_ready) begin
            pkt_log.push_back(pkt_data);
            void'(exp_q.pop_front());
            pkt_due = 1'b0;
          end
        end
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_accept: got word %h expected none", rd_data);
          end else begin
            got++;
            if (got == exp_q[0].nwords) begin
              pkt_due = 1'b1;
              got     = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single packet, header + 2 words
    pkt_log = {};
    words = {16'hAAAA, 16'hBBBB};
    apply_stimulus("s1", 7'd5, 2, 1'b0);
    wait_done("s1");
    check_output("s1_count", 48'(pkt_log.size()), 48'd1);
    if (pkt_log.size() >= 1) check_output("s1_pkt0", pkt_log[0], 48'h8502_AAAA_BBBB);

    // 2: two packets, second full
    pkt_log = {};
    make_words(16'h0001, 5);
    apply_stimulus("s2", 7'd1, 5, 1'b0);
    wait_done("s2");
    check_output("s2_count", 48'(pkt_log.size()), 48'd2);
    if (pkt_log.size() >= 2) begin
      check_output("s2_pkt0", pkt_log[0], 48'h8105_0001_0002);
      check_output("s2_pkt1", pkt_log[1], 48'h0003_0004_0005);
    end

    // 3: zero-padded tail
    pkt_log = {};
    make_words(16'h0001, 3);
    apply_stimulus("s3", 7'h12, 3, 1'b0);
    wait_done("s3");
    check_output("s3_count", 48'(pkt_log.size()), 48'd2);
    if (pkt_log.size() >= 2) begin
      check_output("s3_pkt0", pkt_log[0], 48'h9203_0001_0002);
      check_output("s3_pkt1", pkt_log[1], 48'h0003_0000_0000);
    end

    // 4: back-pressure in SEND for 4 cycles
    pkt_log = {};
    stalled = 0;
    stall_cnt = 4;
    make_words(16'h1000, 5);
    apply_stimulus("s4", 7'd3, 5, 1'b0);
    wait_done("s4");
    check_output("s4_stalled", 48'(stalled), 48'd4);
    check_output("s4_count", 48'(pkt_log.size()), 48'd2);
    if (pkt_log.size() >= 2) check_output("s4_pkt1", pkt_log[1], 48'h1002_1003_1004);

    // 5: zero-length start, then a start while busy
    pkt_log = {};
    apply_stimulus("s5_len0", 7'd4, 0, 1'b1);
    check_output("s5_len0_busy", 48'(busy), 48'd0);
    make_words(16'hC000, 4);
    apply_stimulus("s5_go", 7'd7, 4, 1'b0);
    check_output("s5_busy", 48'(busy), 48'd1);
    apply_stimulus("s5_busy_start", 7'd9, 3, 1'b1);
    wait_done("s5");
    check_output("s5_count", 48'(pkt_log.size()), 48'd2);
    if (pkt_log.size() >= 2) begin
      check_output("s5_pkt0", pkt_log[0], 48'h8704_C000_C001);
      check_output("s5_pkt1", pkt_log[1], 48'hC002_C003_0000);
    end

    // 6: reset mid-FILL, then a fresh response
    make_words(16'hE000, 5);
    rd_start  = 1'b1;
    rd_slv_id = 7'd2;
    rd_length = 8'd5;
    build_packets(7'd2, 5);
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    src_q.delete();
    got = 0;
    pkt_due = 1'b0;
    rd_valid = 1'b0;
    #1 check_reset_outputs("s6_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pkt_log = {};
    words = {16'h5A5A, 16'hA5A5};
    apply_stimulus("s6", 7'd9, 2, 1'b0);
    wait_done("s6");
    check_output("s6_count", 48'(pkt_log.size()), 48'd1);
    if (pkt_log.size() >= 1) check_output("s6_pkt0", pkt_log[0], 48'h8902_5A5A_A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
